// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch/decode/issue front end:
// sequencer states, opcode map, IR field layout and default vectors.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_INTR,
    ST_HALT
  } state_t;

  localparam int OPCODE_W    = 4;
  localparam int OPERAND_W   = 4;
  localparam int OPCODE_MSB  = 7;
  localparam int OPCODE_LSB  = 4;
  localparam int OPERAND_MSB = 3;
  localparam int OPERAND_LSB = 0;

  // ALU opcodes occupy 0-7 so bit 3 of the opcode cleanly separates them
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_NOT = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_SHL = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_SHR = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_ION = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_IOF = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_RTI = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  localparam logic [3:0] DEF_RESET_VECTOR = 4'h0;
  localparam logic [3:0] DEF_INT_VECTOR   = 4'hF;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits IR into fields and flags the
// opcode class. Kept stand-alone so later pipeline stages can reuse it.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0]           ir,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [OPERAND_W-1:0] operand,
  output logic                 is_alu,
  output logic                 is_jmp,
  output logic                 is_ion,
  output logic                 is_iof,
  output logic                 is_rti,
  output logic                 is_hlt
);

  assign opcode  = ir[OPCODE_MSB:OPCODE_LSB];
  assign operand = ir[OPERAND_MSB:OPERAND_LSB];

  assign is_alu = (opcode[OPCODE_W-1] == 1'b0);
  assign is_jmp = (opcode == OP_JMP);
  assign is_ion = (opcode == OP_ION);
  assign is_iof = (opcode == OP_IOF);
  assign is_rti = (opcode == OP_RTI);
  assign is_hlt = (opcode == OP_HLT);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch/decode/issue sequencer in front of the ALU datapath: fetches over
// req/ack, runs control-flow opcodes locally, issues ALU ops over valid/ready.
module instr_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W       = 4,
  parameter int                 DATA_W       = 8,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0]  INT_VECTOR   = ADDR_W'(DEF_INT_VECTOR)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  output logic                 MEM_REQ,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  input  logic                 MEM_ACK,
  input  logic [DATA_W-1:0]    MEM_RDATA,
  input  logic                 INTR,
  output logic                 OP_VALID,
  input  logic                 OP_READY,
  output logic [OPCODE_W-1:0]  OPCODE,
  output logic [OPERAND_W-1:0] OPERAND,
  output logic [ADDR_W-1:0]    PC,
  output logic [DATA_W-1:0]    IR,
  output logic                 IEN,
  output logic                 HALTED
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [ADDR_W-1:0]   saved_pc_reg, saved_pc_next;
  logic [DATA_W-1:0]   ir_reg, ir_next;
  logic                ien_reg, ien_next;

  logic [OPCODE_W-1:0]  dec_opcode;
  logic [OPERAND_W-1:0] dec_operand;
  logic dec_alu, dec_jmp, dec_ion, dec_iof, dec_rti, dec_hlt;
  logic take_intr;

  instr_decoder u_decoder (
    .ir      (ir_reg),
    .opcode  (dec_opcode),
    .operand (dec_operand),
    .is_alu  (dec_alu),
    .is_jmp  (dec_jmp),
    .is_ion  (dec_ion),
    .is_iof  (dec_iof),
    .is_rti  (dec_rti),
    .is_hlt  (dec_hlt)
  );

  // Uses the registered IEN, so ION/IOF/RTI only affect later boundaries
  assign take_intr = INTR && ien_reg;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    saved_pc_next = saved_pc_reg;
    ir_next       = ir_reg;
    ien_next      = ien_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        if (MEM_ACK) begin
          ir_next    = MEM_RDATA;
          pc_next    = pc_reg + ADDR_W'(1);
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_alu) begin
          state_next = ST_ISSUE;
        end else if (dec_hlt) begin
          state_next = ST_HALT;
        end else begin
          if (dec_jmp) pc_next = ADDR_W'(dec_operand);
          if (dec_ion) ien_next = 1'b1;
          if (dec_iof) ien_next = 1'b0;
          if (dec_rti) begin
            pc_next  = saved_pc_reg;
            ien_next = 1'b1;
          end
          state_next = take_intr ? ST_INTR : ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (OP_READY) state_next = take_intr ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        saved_pc_next = pc_reg;
        pc_next       = INT_VECTOR;
        ien_next      = 1'b0;
        state_next    = ST_FETCH;
      end
      ST_HALT: begin
        if (take_intr) state_next = ST_INTR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_VECTOR;
      saved_pc_reg <= '0;
      ir_reg       <= '0;
      ien_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      saved_pc_reg <= saved_pc_next;
      ir_reg       <= ir_next;
      ien_reg      <= ien_next;
    end
  end

  assign MEM_REQ  = (state_reg == ST_FETCH);
  assign OP_VALID = (state_reg == ST_ISSUE);
  assign HALTED   = (state_reg == ST_HALT);
  assign MEM_ADDR = pc_reg;
  assign PC       = pc_reg;
  assign IR       = ir_reg;
  assign IEN      = ien_reg;
  assign OPCODE   = dec_opcode;
  assign OPERAND  = dec_operand;

endmodule
